// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the even-parity helper also used by the transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;
  localparam int unsigned PARITY_MAX_W   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Tick index at the middle of the start bit.
  function automatic int unsigned mid_tick(input int unsigned oversample);
    return oversample / 2 - 1;
  endfunction

  // Tick index one full bit period after the previous sample point.
  function automatic int unsigned last_tick(input int unsigned oversample);
    return oversample - 1;
  endfunction

  // Zero-extension does not change the result, so narrower words are widened by the caller.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// System-side bundle of the UART receiver: baud tick, serial line, received byte and flags.
interface uart_receiver_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic                 sample_ENABLE;
  logic                 Rx_EN;
  logic                 RxD;
  logic [DATA_BITS-1:0] Rx_DATA;
  logic                 Rx_VALID;
  logic                 Rx_FERROR;
  logic                 Rx_PERROR;

  modport master (
    output sample_ENABLE, Rx_EN, RxD,
    input  Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR
  );

  modport slave (
    input  sample_ENABLE, Rx_EN, RxD,
    output Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR
  );

endinterface

// File: rtl/uart_rx_sync.sv
// RxD two-flop synchroniser and rising-edge detector turning the baud
// controller's square wave into a single-cycle oversample tick.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic sample_ENABLE,
  input  logic rxd,
  output logic rxd_s,
  output logic tick
);

  logic rxd_meta;
  logic sample_prev;

  // Line idles high, so the synchroniser resets to 1 to avoid a phantom start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta    <= 1'b1;
      rxd_s       <= 1'b1;
      sample_prev <= 1'b0;
    end else begin
      rxd_meta    <= rxd;
      rxd_s       <= rxd_meta;
      sample_prev <= sample_ENABLE;
    end
  end

  assign tick = sample_ENABLE & ~sample_prev;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: recovers 8N1/8E1 frames from an oversampled RxD line and
// presents the byte with a one-clk valid strobe plus framing/parity flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned PARITY_EN  = 1
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.slave  rx_if
);

  localparam int unsigned TCW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_BITS + 1);
  localparam logic [TCW-1:0] MID_T    = TCW'(mid_tick(OVERSAMPLE));
  localparam logic [TCW-1:0] LAST_T   = TCW'(last_tick(OVERSAMPLE));
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  logic rxd_s;
  logic tick;

  rx_state_e state, state_nxt;

  logic [TCW-1:0]       tick_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 perr;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferror_q;
  logic                 perror_q;

  logic at_mid, at_last;
  logic tick_clr, tick_inc, bit_clr, shift_en, par_cap, frame_done;

  uart_rx_sync u_sync (
    .clk           (clk),
    .reset         (reset),
    .sample_ENABLE (rx_if.sample_ENABLE),
    .rxd           (rx_if.RxD),
    .rxd_s         (rxd_s),
    .tick          (tick)
  );

  assign at_mid  = tick && (tick_cnt == MID_T);
  assign at_last = tick && (tick_cnt == LAST_T);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; a low enable overrides everything and parks the FSM in IDLE.
  always_comb begin
    state_nxt = state;
    if (!rx_if.Rx_EN) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (tick && !rxd_s) state_nxt = START;
        START:   if (at_mid) state_nxt = rxd_s ? IDLE : DATA;
        DATA:    if (at_last && (bit_cnt == BIT_LAST))
                   state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY:  if (at_last) state_nxt = STOP;
        STOP:    if (at_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath strobes derived from the current state and tick position.
  always_comb begin
    tick_clr   = 1'b0;
    tick_inc   = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    par_cap    = 1'b0;
    frame_done = 1'b0;
    if (!rx_if.Rx_EN) begin
      tick_clr = 1'b1;
      bit_clr  = 1'b1;
    end else begin
      tick_clr   = (state_nxt != state) || at_last;
      tick_inc   = tick && (state != IDLE);
      bit_clr    = (state_nxt != state);
      shift_en   = (state == DATA)   && at_last;
      par_cap    = (state == PARITY) && at_last;
      frame_done = (state == STOP)   && at_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      perr      <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferror_q  <= 1'b0;
      perror_q  <= 1'b0;
    end else begin
      if (tick_clr)      tick_cnt <= '0;
      else if (tick_inc) tick_cnt <= tick_cnt + TCW'(1);

      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + BCW'(1);

      if (shift_en) shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
      if (par_cap)  perr      <= even_parity(PARITY_MAX_W'(shift_reg)) ^ rxd_s;

      // Stop-bit sample point: publish the frame on the following clk.
      valid_q <= frame_done;
      if (frame_done) begin
        data_q   <= shift_reg;
        ferror_q <= ~rxd_s;
        perror_q <= (PARITY_EN != 0) ? perr : 1'b0;
      end
    end
  end

  assign rx_if.Rx_DATA   = data_q;
  assign rx_if.Rx_VALID  = valid_q;
  assign rx_if.Rx_FERROR = ferror_q;
  assign rx_if.Rx_PERROR = perror_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: good, parity-error, framing-error, glitch,
// back-to-back, enable-abort and reset-abort frames with hand-computed results.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int unsigned DW            = 8;
  localparam int unsigned HALF_TICK_CLK = 14;
  localparam int unsigned OS            = 16;
  localparam int unsigned TICK_CLK      = 2 * HALF_TICK_CLK;
  localparam int unsigned BIT_CLK       = TICK_CLK * OS;

  logic clk = 1'b0;
  logic reset;

  uart_receiver_if #(.DATA_BITS(DW)) rif ();

  uart_receiver #(
    .DATA_BITS  (DW),
    .OVERSAMPLE (OS),
    .PARITY_EN  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx_if (rif)
  );

  always #10 clk = ~clk;

  initial begin
    rif.sample_ENABLE = 1'b0;
    forever begin
      repeat (HALF_TICK_CLK) @(negedge clk);
      rif.sample_ENABLE = ~rif.sample_ENABLE;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Valid-pulse monitor: counts pulses, captures payload at the first high cycle, records width.
  int          vcount     = 0;
  int          run_len    = 0;
  int          last_width = 0;
  logic [DW-1:0] cap_data = '0;
  logic        cap_fe     = 1'b0;
  logic        cap_pe     = 1'b0;

  always @(negedge clk) begin
    if (rif.Rx_VALID === 1'b1) begin
      if (run_len == 0) begin
        vcount++;
        cap_data = rif.Rx_DATA;
        cap_fe   = rif.Rx_FERROR;
        cap_pe   = rif.Rx_PERROR;
      end
      run_len++;
    end else begin
      if (run_len != 0) last_width = run_len;
      run_len = 0;
    end
  end

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rif.RxD = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ par_flip);
    send_bit(stop_b);
    rif.RxD = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input int n0, input logic [7:0] d,
                              input logic fe, input logic pe);
    check({tag, "_count"}, 32'(vcount), 32'(n0 + 1));
    check({tag, "_data"},  32'(cap_data), 32'(d));
    check({tag, "_ferr"},  32'(cap_fe), 32'(fe));
    check({tag, "_perr"},  32'(cap_pe), 32'(pe));
    check({tag, "_width"}, 32'(last_width), 32'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int          n;
  logic [7:0]  partial;

  initial begin
    reset     = 1'b1;
    rif.Rx_EN = 1'b1;
    rif.RxD   = 1'b1;
    wait_clk(5);
    check("rst_data",  32'(rif.Rx_DATA),   32'h0);
    check("rst_valid", 32'(rif.Rx_VALID),  32'h0);
    check("rst_ferr",  32'(rif.Rx_FERROR), 32'h0);
    check("rst_perr",  32'(rif.Rx_PERROR), 32'h0);
    check("rst_state", 32'(dut.state),     32'(IDLE));
    reset = 1'b0;
    wait_clk(BIT_CLK);

    n = vcount; send_frame(8'hA5, 1'b0, 1'b1); expect_frame("a5", n, 8'hA5, 1'b0, 1'b0);
    wait_clk(BIT_CLK);
    n = vcount; send_frame(8'h3C, 1'b1, 1'b1); expect_frame("3c_par", n, 8'h3C, 1'b0, 1'b1);
    wait_clk(BIT_CLK);
    n = vcount; send_frame(8'h81, 1'b0, 1'b0); expect_frame("81_stop", n, 8'h81, 1'b1, 1'b0);
    wait_clk(2 * BIT_CLK);
    check("break_nopulse", 32'(vcount), 32'(n + 1));
    n = vcount; send_frame(8'h55, 1'b0, 1'b1); expect_frame("55", n, 8'h55, 1'b0, 1'b0);
    wait_clk(BIT_CLK);

    // Five-tick low glitch on an idle line.
    n = vcount;
    rif.RxD = 1'b0; wait_clk(5 * TICK_CLK);
    rif.RxD = 1'b1; wait_clk(BIT_CLK);
    check("glitch_nopulse", 32'(vcount),       32'(n));
    check("glitch_state",   32'(dut.state),    32'(IDLE));
    check("glitch_hold",    32'(rif.Rx_DATA),  32'h55);

    n = vcount; send_frame(8'h00, 1'b0, 1'b1); expect_frame("b2b_00", n, 8'h00, 1'b0, 1'b0);
    n = vcount; send_frame(8'hFF, 1'b0, 1'b1); expect_frame("b2b_ff", n, 8'hFF, 1'b0, 1'b0);
    wait_clk(BIT_CLK);

    // Enable dropped after three data bits of 0x5A.
    partial = 8'h5A;
    n = vcount;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(partial[i]);
    rif.Rx_EN = 1'b0;
    rif.RxD   = 1'b1;
    wait_clk(2 * BIT_CLK);
    check("abort_nopulse", 32'(vcount),      32'(n));
    check("abort_state",   32'(dut.state),   32'(IDLE));
    check("abort_hold",    32'(rif.Rx_DATA), 32'hFF);
    rif.Rx_EN = 1'b1;
    wait_clk(BIT_CLK);
    n = vcount; send_frame(8'hC3, 1'b0, 1'b1); expect_frame("en_c3", n, 8'hC3, 1'b0, 1'b0);
    wait_clk(BIT_CLK);

    // Same partial frame, aborted by reset instead.
    n = vcount;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(partial[i]);
    reset = 1'b1;
    wait_clk(3);
    check("mrst_data",  32'(rif.Rx_DATA),   32'h0);
    check("mrst_valid", 32'(rif.Rx_VALID),  32'h0);
    check("mrst_ferr",  32'(rif.Rx_FERROR), 32'h0);
    check("mrst_perr",  32'(rif.Rx_PERROR), 32'h0);
    check("mrst_state", 32'(dut.state),     32'(IDLE));
    rif.RxD = 1'b1;
    reset   = 1'b0;
    wait_clk(2 * BIT_CLK);
    check("mrst_nopulse", 32'(vcount), 32'(n));
    n = vcount; send_frame(8'hC3, 1'b0, 1'b1); expect_frame("rst_c3", n, 8'hC3, 1'b0, 1'b0);
    wait_clk(BIT_CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
